// File: rtl/bram_log_ctrl_if.sv
// rtl/bram_log_ctrl_if.sv - capture source, readout handshake and BRAM bus bundle
interface bram_log_ctrl_if #(
  parameter int BRAM_ADDR_WIDTH = 15,
  parameter int BRAM_DATA_WIDTH = 16
);
  logic                       log_start;
  logic                       log_stop;
  logic                       log_valid;
  logic [BRAM_DATA_WIDTH-1:0] log_data;
  logic                       log_busy;
  logic                       log_full;
  logic [BRAM_ADDR_WIDTH:0]   log_count;

  logic                       rd_req;
  logic [BRAM_ADDR_WIDTH-1:0] rd_addr;
  logic                       rd_ack;
  logic                       rd_valid;
  logic [BRAM_DATA_WIDTH-1:0] rd_data;

  logic [BRAM_ADDR_WIDTH-1:0] bram_addr;
  logic                       bram_chipselect_n;
  logic                       bram_write_n;
  logic                       bram_read_n;
  logic [BRAM_DATA_WIDTH-1:0] bram_data_in;
  logic [BRAM_DATA_WIDTH-1:0] bram_data_out;

  // Controller side
  modport slave (
    input  log_start, log_stop, log_valid, log_data, rd_req, rd_addr, bram_data_out,
    output log_busy, log_full, log_count, rd_ack, rd_valid, rd_data,
           bram_addr, bram_chipselect_n, bram_write_n, bram_read_n, bram_data_in
  );

  // Environment side: sample source, host requester and the BRAM itself
  modport master (
    output log_start, log_stop, log_valid, log_data, rd_req, rd_addr, bram_data_out,
    input  log_busy, log_full, log_count, rd_ack, rd_valid, rd_data,
           bram_addr, bram_chipselect_n, bram_write_n, bram_read_n, bram_data_in
  );
endinterface

// File: rtl/bram_log_ctrl.sv
// rtl/bram_log_ctrl.sv - capture sequencer and write-priority arbiter for a single-port sample BRAM
module bram_log_ctrl #(
  parameter int BRAM_ADDR_WIDTH = 15,
  parameter int BRAM_DATA_WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  bram_log_ctrl_if.slave  bus
);
  localparam int AW = BRAM_ADDR_WIDTH;
  localparam int DW = BRAM_DATA_WIDTH;
  localparam logic [AW:0] COUNT_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_LOG, S_FULL} state_e;

  state_e          state_q, state_d;
  logic [AW:0]     count_q, count_d;
  logic            log_busy_q, log_busy_d;
  logic            log_full_q, log_full_d;
  logic            rd_ack_q, rd_ack_d;
  logic            rd_pend_q, rd_pend_d;
  logic            rd_valid_q, rd_valid_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic [AW-1:0]   bram_addr_q, bram_addr_d;
  logic            cs_n_q, cs_n_d;
  logic            wr_n_q, wr_n_d;
  logic            rd_n_q, rd_n_d;
  logic [DW-1:0]   din_q, din_d;
  logic            wr_en;
  logic            rd_en;
  logic            last_addr;

  // Arbitration: a capture write owns the port; a read only fills an idle cycle.
  // A sample coinciding with a restart is dropped, so it does not block a read.
  always_comb begin
    wr_en     = (state_q == S_LOG) && bus.log_valid && !bus.log_start;
    rd_en     = !wr_en && bus.rd_req;
    last_addr = (count_q[AW-1:0] == {AW{1'b1}});
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      log_busy_q  <= 1'b0;
      log_full_q  <= 1'b0;
      rd_ack_q    <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      bram_addr_q <= '0;
      cs_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      din_q       <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      log_busy_q  <= log_busy_d;
      log_full_q  <= log_full_d;
      rd_ack_q    <= rd_ack_d;
      rd_pend_q   <= rd_pend_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      bram_addr_q <= bram_addr_d;
      cs_n_q      <= cs_n_d;
      wr_n_q      <= wr_n_d;
      rd_n_q      <= rd_n_d;
      din_q       <= din_d;
    end
  end

  // Next state: start always (re)enters LOG; filling the last word wins over stop
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_FULL: begin
        if (bus.log_start) state_d = S_LOG;
      end
      S_LOG: begin
        if (bus.log_start)            state_d = S_LOG;
        else if (wr_en && last_addr)  state_d = S_FULL;
        else if (bus.log_stop)        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs: sample counter, BRAM strobes and the 2-stage read return
  always_comb begin
    count_d = count_q;
    if (bus.log_start) count_d = '0;
    else if (wr_en)    count_d = count_q + COUNT_ONE;

    log_busy_d = (state_d == S_LOG);
    log_full_d = (state_d == S_FULL);

    rd_ack_d   = rd_en;
    rd_pend_d  = rd_ack_q;
    rd_valid_d = rd_pend_q;
    rd_data_d  = rd_pend_q ? bus.bram_data_out : rd_data_q;

    cs_n_d = !(wr_en || rd_en);
    wr_n_d = !wr_en;
    rd_n_d = !rd_en;

    bram_addr_d = bram_addr_q;
    if (wr_en)      bram_addr_d = count_q[AW-1:0];
    else if (rd_en) bram_addr_d = bus.rd_addr;

    din_d = wr_en ? bus.log_data : din_q;
  end

  assign bus.log_busy          = log_busy_q;
  assign bus.log_full          = log_full_q;
  assign bus.log_count         = count_q;
  assign bus.rd_ack            = rd_ack_q;
  assign bus.rd_valid          = rd_valid_q;
  assign bus.rd_data           = rd_data_q;
  assign bus.bram_addr         = bram_addr_q;
  assign bus.bram_chipselect_n = cs_n_q;
  assign bus.bram_write_n      = wr_n_q;
  assign bus.bram_read_n       = rd_n_q;
  assign bus.bram_data_in      = din_q;
endmodule

// File: doc/bram_log_ctrl.md
# bram_log_ctrl

Sequencing and arbitration controller for the single-port sample BRAM (`bram`, 1-cycle registered read). It runs a capture sequence that writes a streaming sample source into consecutive BRAM addresses until memory is full or capture is stopped. It also serves random-access readout requests from the host/UART side. Capture writes always win the shared port; readouts are granted in the gaps.

## Interface
- `BRAM_ADDR_WIDTH`, default 15: BRAM address width; depth is 2^`BRAM_ADDR_WIDTH` words.
- `BRAM_DATA_WIDTH`, default 16: sample/word width.

- `clk`  in  1  single system clock, all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `log_start`  in  1  pulse that starts or restarts capture at address 0.
- `log_stop`  in  1  pulse that ends capture early.
- `log_valid`  in  1  sample qualifier; the source has no backpressure.
- `log_data`  in  `BRAM_DATA_WIDTH`  sample.
- `log_busy`  out  1  high while in LOG.
- `log_full`  out  1  high in FULL.
- `log_count`  out  `BRAM_ADDR_WIDTH`+1  number of samples written in the current/last capture.
- `rd_req`  in  1  readout request; held with `rd_addr` until `rd_ack`.
- `rd_addr`  in  `BRAM_ADDR_WIDTH`  readout address.
- `rd_ack`  out  1  1-cycle grant pulse.
- `rd_valid`  out  1  1-cycle pulse marking `rd_data`.
- `rd_data`  out  `BRAM_DATA_WIDTH`  read word, held until the next `rd_valid`.
- `bram_addr`  out  `BRAM_ADDR_WIDTH`  to BRAM `addr`.
- `bram_chipselect_n`, `bram_write_n`, `bram_read_n`  out  1 each  active-low strobes to BRAM.
- `bram_data_in`  out  `BRAM_DATA_WIDTH`  write data to BRAM.
- `bram_data_out`  in  `BRAM_DATA_WIDTH`  read data from BRAM.

## Operation
- **FSM states.** IDLE, LOG, FULL.
  - IDLE/FULL + `log_start` -> LOG. This clears the write pointer and `log_count` to 0 and clears `log_full`.
  - LOG + `log_start` -> LOG, restarted: pointer=0, count=0. A `log_valid` in the same cycle is dropped.
  - LOG + `log_stop` -> IDLE. A `log_valid` in the same cycle is still written. If `log_stop` and `log_start` coincide, `log_start` wins.
  - LOG: each `log_valid` writes `log_data` at the pointer, then increments the pointer and `log_count`.
  - The write to address 2^AW-1 makes `log_count`=2^AW and moves the FSM to FULL. No wrap-around and no overwrite.
  - FULL: `log_valid` is ignored; `log_stop` is ignored.
- **Arbitration, evaluated every cycle.**
  - A write (LOG and `log_valid`) is issued that cycle.
  - Otherwise, if `rd_req`, a read of `rd_addr` is issued and `rd_ack` pulses.
  - Otherwise no access (`bram_chipselect_n`=1).
  - Reads are allowed in all states, including during LOG. A continuous `log_valid` starves readout; this is by design.
- **Strobes.** At most one of write/read per access; `bram_chipselect_n` is low only when an access is issued.
- **Outputs.** All outputs are registered.
- **Reset values.** `rst_n`=0 at an edge -> IDLE, pointer/count=0, `log_busy`=0, `log_full`=0, `rd_ack`=0, `rd_valid`=0, `rd_data`=0, `bram_chipselect_n`=1, `bram_write_n`=1, `bram_read_n`=1, `bram_addr`=0, `bram_data_in`=0.
- **Reset mid-read.** An in-flight read is discarded: no `rd_valid` after reset.

## Timing
- **Decision and strobes.** The decision is made on inputs sampled at edge k. The BRAM strobes, address and data are registered at k and seen by the BRAM at edge k+1.
- **Write.** `log_valid` at edge k -> memory updated at edge k+1. `log_count`/`log_full` update at edge k.
- **Read.** `rd_req` granted at edge k -> `rd_ack`=1 in cycle k..k+1. The BRAM outputs data after k+1. `rd_data` is registered and `rd_valid`=1 after edge k+2, so latency is 2 cycles from grant.
- **Back-to-back reads.** The requester may present the next `rd_req`/`rd_addr` in the cycle after `rd_ack`. This gives a throughput of 1 read/cycle when not logging, with pipelined `rd_valid`.
- **Same-address case.** A read of an address written in the same cycle is impossible: a write takes priority. A read granted the cycle after a write to the same address returns the new data.

## Test plan
- **Reset.** Hold `rst_n`=0 for 3 cycles with random inputs -> all outputs at their reset values; `bram_chipselect_n`=1 throughout.
- **Short capture.** AW=4: `log_start`, then 5 samples 0x11..0x15 with gaps, then `log_stop` -> `log_count`=5, IDLE. Reads of addresses 0..4 return 0x11..0x15, each `rd_valid` 2 cycles after its `rd_ack`.
- **Full.** AW=4: `log_start`, then 20 consecutive `log_valid` -> `log_full`=1 after the 16th write and `log_count`=16. Samples 17-20 are not written; address 0 still holds sample 1.
- **Arbitration.** `rd_req` held during LOG with `log_valid` pattern 1,1,0 -> `rd_ack` only in the `log_valid`=0 cycle. `rd_data` equals the value previously written at `rd_addr`.
- **Restart.** `log_start` during LOG at count 7 -> `log_count`=0. The next sample goes to address 0.
- **Reset mid-read.** `rst_n` low 1 cycle after `rd_ack` -> no `rd_valid` pulse.
